// File: rtl/ms_sample_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ms_sample_scheduler: 1 kHz tick sync, ms timestamp, periodic sample req;  |
// | optional timeout via SAMPLE_TIMEOUT_EN.  Revision 1.0                     |
// +--------------------------------------------------------------------------+
module ms_sample_scheduler #(
  parameter int unsigned PERIOD_MS  = 10,
  parameter int unsigned TIMEOUT_MS = 5
) (
  input  logic        CLK_1MHZ_IN,
  input  logic        RESET,
  input  logic        CLK_1KHZ_IN,
  input  logic        SAMPLE_ACK,
  output logic        TICK_1KHZ,
  output logic [31:0] TIMESTAMP_MS,
  output logic        SAMPLE_REQ,
  output logic [31:0] SAMPLE_TS,
  output logic [7:0]  MISSED_COUNT,
  output logic        TIMEOUT_FLAG
);

  localparam logic [0:0]  S_IDLE     = 1'b0;
  localparam logic [0:0]  S_REQ      = 1'b1;
  localparam logic [15:0] PHASE_LAST = 16'(PERIOD_MS - 1);

  if (PERIOD_MS < 1 || PERIOD_MS > 65535) begin : g_bad_period
    $error("PERIOD_MS out of range 1..65535");
  end
  if (TIMEOUT_MS < 1 || TIMEOUT_MS > 255) begin : g_bad_timeout
    $error("TIMEOUT_MS out of range 1..255");
  end

  logic        s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic        tick_q, tick_d;
  logic [31:0] timestamp_q, timestamp_d;
  logic [15:0] phase_q, phase_d;
  logic [0:0]  state_q, state_d;
  logic [31:0] sample_ts_q, sample_ts_d;
  logic [7:0]  missed_q, missed_d;
  logic        period_evt;
  logic        timeout_hit;

  // State register
  always_ff @(posedge CLK_1MHZ_IN) begin
    if (RESET) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      tick_q      <= 1'b0;
      timestamp_q <= 32'd0;
      phase_q     <= 16'd0;
      state_q     <= S_IDLE;
      sample_ts_q <= 32'd0;
      missed_q    <= 8'd0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      tick_q      <= tick_d;
      timestamp_q <= timestamp_d;
      phase_q     <= phase_d;
      state_q     <= state_d;
      sample_ts_q <= sample_ts_d;
      missed_q    <= missed_d;
    end
  end

  // The divided clock is plain data: two-flop sync plus one flop for edge detect.
  always_comb begin
    s1_d        = CLK_1KHZ_IN;
    s2_d        = s1_q;
    s3_d        = s2_q;
    tick_d      = s2_q & ~s3_q;
    timestamp_d = timestamp_q;
    phase_d     = phase_q;
    period_evt  = 1'b0;
    if (tick_q) begin
      timestamp_d = timestamp_q + 32'd1;
      if (phase_q == PHASE_LAST) begin
        phase_d    = 16'd0;
        period_evt = 1'b1;
      end else begin
        phase_d = phase_q + 16'd1;
      end
    end
  end

`ifdef SAMPLE_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT_MS);

  logic [7:0] to_cnt_q, to_cnt_d;
  logic       flag_q, flag_d;

  always_ff @(posedge CLK_1MHZ_IN) begin
    if (RESET) begin
      to_cnt_q <= 8'd0;
      flag_q   <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      flag_q   <= flag_d;
    end
  end

  // Held at zero in IDLE so every request starts its timeout window fresh.
  always_comb begin
    to_cnt_d    = to_cnt_q;
    flag_d      = flag_q;
    timeout_hit = 1'b0;
    if (state_q == S_IDLE) begin
      to_cnt_d = 8'd0;
    end else if (tick_q) begin
      to_cnt_d = to_cnt_q + 8'd1;
      if (to_cnt_d == TIMEOUT_CNT && !SAMPLE_ACK) begin
        timeout_hit = 1'b1;
        flag_d      = 1'b1;
      end
    end
  end

  assign TIMEOUT_FLAG = flag_q;
`else
  assign timeout_hit  = 1'b0;
  assign TIMEOUT_FLAG = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (period_evt) state_d = S_REQ;
      S_REQ:   if (SAMPLE_ACK || timeout_hit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A period event while a request is outstanding is always a miss, even if
  // the same cycle completes that request.
  always_comb begin
    sample_ts_d = sample_ts_q;
    missed_d    = missed_q;
    if (state_q == S_IDLE && period_evt) begin
      sample_ts_d = timestamp_d;
    end
    if (state_q == S_REQ && period_evt && missed_q != 8'hFF) begin
      missed_d = missed_q + 8'd1;
    end
  end

  assign TICK_1KHZ    = tick_q;
  assign TIMESTAMP_MS = timestamp_q;
  assign SAMPLE_REQ   = (state_q == S_REQ);
  assign SAMPLE_TS    = sample_ts_q;
  assign MISSED_COUNT = missed_q;

endmodule
`default_nettype wire

// File: tb/tb_ms_sample_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ms_sample_scheduler: scoreboard bench for ms_sample_scheduler.         |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_ms_sample_scheduler;

  localparam int HALF = 20;  // system cycles per half of the divided clock

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_1k;
  logic        ack;
  logic        tick;
  logic [31:0] ts;
  logic        req;
  logic [31:0] sample_ts;
  logic [7:0]  missed;
  logic        flag;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  bit          auto_ack = 1'b0;
  int          req_age = 0;
  bit          req_prev;

  ms_sample_scheduler #(.PERIOD_MS(10), .TIMEOUT_MS(5)) dut (
    .CLK_1MHZ_IN (clk),
    .RESET       (rst),
    .CLK_1KHZ_IN (clk_1k),
    .SAMPLE_ACK  (ack),
    .TICK_1KHZ   (tick),
    .TIMESTAMP_MS(ts),
    .SAMPLE_REQ  (req),
    .SAMPLE_TS   (sample_ts),
    .MISSED_COUNT(missed),
    .TIMEOUT_FLAG(flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One system cycle; the ack agent answers 3 cycles after it sees a request.
  task automatic cyc();
    @(negedge clk);
    if (auto_ack) begin
      if (req) begin
        req_age++;
        ack = (req_age == 3);
      end else begin
        req_age = 0;
        ack     = 1'b0;
      end
    end
  endtask

  task automatic ms(input int n);
    repeat (n) begin
      clk_1k = 1'b1;
      repeat (HALF) cyc();
      clk_1k = 1'b0;
      repeat (HALF) cyc();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    clk_1k   = 1'b0;
    ack      = 1'b0;
    auto_ack = 1'b0;
    req_age  = 0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tick"},   {31'd0, tick}, 32'd0);
    check({tag, "_ts"},     ts, 32'd0);
    check({tag, "_req"},    {31'd0, req}, 32'd0);
    check({tag, "_sts"},    sample_ts, 32'd0);
    check({tag, "_missed"}, {24'd0, missed}, 32'd0);
    check({tag, "_flag"},   {31'd0, flag}, 32'd0);
  endtask

  // Monitor: every new request is matched against the scoreboard queue.
  initial begin
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (req && !req_prev) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_req: got SAMPLE_TS 0x%0h expected no request", sample_ts);
        end else begin
          check("req_ts", sample_ts, exp_q.pop_front());
        end
      end
      req_prev = req;
    end
  end

  initial begin
    rst = 1'b1; clk_1k = 1'b0; ack = 1'b0;
    do_reset();
    check_all_zero("reset");

    // Single rising edge: tick on the 3rd edge, timestamp one cycle after.
    repeat (3) @(negedge clk);
    clk_1k = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("tick_early", {31'd0, tick}, 32'd0);
    @(negedge clk);
    check("tick_pulse", {31'd0, tick}, 32'd1);
    check("ts_before", ts, 32'd0);
    @(negedge clk);
    check("tick_end", {31'd0, tick}, 32'd0);
    check("ts_after", ts, 32'd1);
    repeat (10) @(negedge clk);
    check("ts_held_high", ts, 32'd1);
    clk_1k = 1'b0;
    repeat (5) @(negedge clk);

    // 25 ms with prompt acks: two requests at 10 and 20.
    do_reset();
    auto_ack = 1'b1;
    exp_q.push_back(32'd10);
    exp_q.push_back(32'd20);
    ms(25);
    check("run_ts", ts, 32'd25);
    check("run_missed", {24'd0, missed}, 32'd0);
    check("run_req", {31'd0, req}, 32'd0);
    check("run_sts", sample_ts, 32'd20);
    check("run_queue", exp_q.size(), 32'd0);

`ifndef SAMPLE_TIMEOUT_EN
    // Never acked: request persists, two periods missed.
    do_reset();
    exp_q.push_back(32'd10);
    ms(35);
    check("noack_req", {31'd0, req}, 32'd1);
    check("noack_sts", sample_ts, 32'd10);
    check("noack_missed", {24'd0, missed}, 32'd2);
    check("noack_ts", ts, 32'd35);
    check("noack_flag", {31'd0, flag}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    rst = 1'b0;

    // Ack coincident with a period event.
    do_reset();
    exp_q.push_back(32'd10);
    ms(19);
    check("coin_req_pre", {31'd0, req}, 32'd1);
    clk_1k = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("coin_tick", {31'd0, tick}, 32'd1);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("coin_req", {31'd0, req}, 32'd0);
    check("coin_missed", {24'd0, missed}, 32'd1);
    check("coin_ts", ts, 32'd20);
    repeat (HALF - 4) @(negedge clk);
    clk_1k = 1'b0;
    repeat (HALF) @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("idle_ack_req", {31'd0, req}, 32'd0);
    ms(9);
    check("coin_no_req", {31'd0, req}, 32'd0);
    exp_q.push_back(32'd30);
    ms(1);
    check("coin_next_req", {31'd0, req}, 32'd1);
    ack = 1'b1;
    repeat (5) @(negedge clk);
    ack = 1'b0;
    check("held_ack_req", {31'd0, req}, 32'd0);
    exp_q.push_back(32'd40);
    ms(10);
    check("held_next_req", {31'd0, req}, 32'd1);
    check("held_missed", {24'd0, missed}, 32'd1);
`else
    // Timeout after 5 ticks, sticky flag, then reset mid-request.
    do_reset();
    exp_q.push_back(32'd10);
    ms(14);
    check("to_req_pre", {31'd0, req}, 32'd1);
    check("to_flag_pre", {31'd0, flag}, 32'd0);
    ms(1);
    check("to_req", {31'd0, req}, 32'd0);
    check("to_flag", {31'd0, flag}, 32'd1);
    exp_q.push_back(32'd20);
    ms(5);
    check("to_req2", {31'd0, req}, 32'd1);
    check("to_sts2", sample_ts, 32'd20);
    check("to_flag_sticky", {31'd0, flag}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    rst = 1'b0;
`endif

    // Timestamp wrap with a request landing on the wrap.
    do_reset();
    auto_ack = 1'b1;
    ms(8);
    check("wrap_pre", ts, 32'd8);
    force dut.timestamp_q = 32'hFFFF_FFFE;
    #1;
    release dut.timestamp_q;
    @(negedge clk);
    check("wrap_load", ts, 32'hFFFF_FFFE);
    exp_q.push_back(32'd0);
    ms(1);
    check("wrap_ff", ts, 32'hFFFF_FFFF);
    ms(1);
    check("wrap_zero", ts, 32'd0);
    check("wrap_sts", sample_ts, 32'd0);
    repeat (10) cyc();
    check("final_queue", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
